upct_multi: RTL and testbench

- Parametrised, multi-read-port successor to the upper-PC table (UPCT).
- Stores deduplicated upper PC bits so BTB/branch-target entries carry only a short UPCT index instead of full upper PC bits.
- Fetch RESP stage reads READ_PORTS indices per cycle.
- Two-stage update pipeline: CAM lookup in update0, hit or tree-PLRU allocation in update1.
- Adds valid bits, update0/update1 forwarding, an explicit hit flag and a global invalidate.

---
 rtl/core_types_pkg.sv | 11 +
 rtl/upct_plru.sv | 58 +++++
 rtl/upct_multi.sv | 129 ++++++++++++
 tb/tb_upct_multi.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_types_pkg.sv
// Shared core types: upper-PC table sizing and index type.
// Imported by fetch/BTB blocks and the UPCT.
package core_types_pkg;

    localparam int UPCT_ENTRIES     = 8;
    localparam int LOG_UPCT_ENTRIES = $clog2(UPCT_ENTRIES);
    localparam int UPPER_PC_WIDTH   = 22;

    typedef logic [LOG_UPCT_ENTRIES-1:0] upct_idx_t;

endpackage

// File: rtl/upct_plru.sv
// Tree pseudo-LRU over ENTRIES leaves; owns the PLRU state register.
// Ports: CLK, nRST, clear_i (zero the tree), touch_valid_i/touch_index_i
// (applied in ascending order, highest index = most recent), victim_o.
module upct_plru #(
    parameter int ENTRIES     = 8,
    parameter int LOG_ENTRIES = $clog2(ENTRIES),
    parameter int TOUCHES     = 3
) (
    input  logic                                  CLK,
    input  logic                                  nRST,
    input  logic                                  clear_i,
    input  logic [TOUCHES-1:0]                    touch_valid_i,
    input  logic [TOUCHES-1:0][LOG_ENTRIES-1:0]   touch_index_i,
    output logic [LOG_ENTRIES-1:0]                victim_o
);

    localparam int NODES = ENTRIES - 1;

    logic [NODES-1:0] plru_q;
    logic [NODES-1:0] plru_d;

    // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right).
    always_comb begin : victim_walk
        int node;
        node     = 0;
        victim_o = '0;
        for (int lvl = 0; lvl < LOG_ENTRIES; lvl++) begin
            victim_o[LOG_ENTRIES-1-lvl] = plru_q[node];
            node = 2 * node + 1 + int'(plru_q[node]);
        end
    end

    // Each touch points every node on its path away from the touched leaf.
    always_comb begin : touch_seq
        int node;
        node   = 0;
        plru_d = clear_i ? '0 : plru_q;
        for (int t = 0; t < TOUCHES; t++) begin
            if (touch_valid_i[t]) begin
                node = 0;
                for (int lvl = 0; lvl < LOG_ENTRIES; lvl++) begin
                    plru_d[node] = ~touch_index_i[t][LOG_ENTRIES-1-lvl];
                    node = 2 * node + 1
                         + int'(touch_index_i[t][LOG_ENTRIES-1-lvl]);
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            plru_q <= '0;
        end else begin
            plru_q <= plru_d;
        end
    end

endmodule

// File: rtl/upct_multi.sv
// Multi-read-port upper-PC table with two-stage CAM/allocate update path.
// Ports: CLK, nRST, RESP read ports (valid/index/upper PC), update0 request,
// invalidate_all, update1 result (valid/index/hit).
module upct_multi #(
    parameter int UPCT_ENTRIES     = core_types_pkg::UPCT_ENTRIES,
    parameter int LOG_UPCT_ENTRIES = $clog2(UPCT_ENTRIES),
    parameter int UPPER_PC_WIDTH   = core_types_pkg::UPPER_PC_WIDTH,
    parameter int READ_PORTS       = 2
) (
    input  logic                                         CLK,
    input  logic                                         nRST,
    input  logic [READ_PORTS-1:0]                        read_valid_RESP,
    input  logic [READ_PORTS-1:0][LOG_UPCT_ENTRIES-1:0]  read_index_RESP,
    output logic [READ_PORTS-1:0][UPPER_PC_WIDTH-1:0]    read_upper_PC_RESP,
    input  logic                                         update0_valid,
    input  logic [31:0]                                  update0_start_full_PC,
    input  logic                                         invalidate_all,
    output logic                                         update1_valid,
    output logic [LOG_UPCT_ENTRIES-1:0]                  update1_upct_index,
    output logic                                         update1_hit
);

    localparam int IW = LOG_UPCT_ENTRIES;
    localparam int UW = UPPER_PC_WIDTH;

    logic [UPCT_ENTRIES-1:0][UW-1:0] entry_q, entry_d;
    logic [UPCT_ENTRIES-1:0]         valid_q, valid_d;

    logic          u1_valid_q, u1_valid_d;
    logic          u1_hit_q, u1_hit_d;
    logic [UW-1:0] u1_upper_q, u1_upper_d;
    logic [IW-1:0] u1_index_q, u1_index_d;

    logic [IW-1:0] victim;
    logic [IW-1:0] u1_index;
    logic          u1_write;

    logic [UW-1:0]           u0_upper;
    logic [UPCT_ENTRIES-1:0] cam_match;
    logic                    cam_hit;
    logic [IW-1:0]           cam_idx;
    logic                    fwd_hit;

    always_comb begin
        for (int p = 0; p < READ_PORTS; p++) begin
            read_upper_PC_RESP[p] = entry_q[read_index_RESP[p]];
        end
    end

    assign u1_write = u1_valid_q & ~u1_hit_q;
    assign u1_index = u1_hit_q ? u1_index_q : victim;

    assign update1_valid      = u1_valid_q;
    assign update1_hit        = u1_hit_q;
    assign update1_upct_index = u1_valid_q ? u1_index : '0;

    assign u0_upper = update0_start_full_PC[31 -: UW];

    // An entry being overwritten by update1 this cycle must not match on
    // its old contents; the new contents are caught by forwarding instead.
    always_comb begin
        cam_idx = '0;
        for (int i = 0; i < UPCT_ENTRIES; i++) begin
            cam_match[i] = valid_q[i]
                         & (entry_q[i] == u0_upper)
                         & ~invalidate_all
                         & ~(u1_write & (u1_index == IW'(i)));
            if (cam_match[i]) begin
                cam_idx = cam_idx | IW'(i);
            end
        end
        cam_hit = |cam_match;
    end

    assign fwd_hit = u1_valid_q & (u1_upper_q == u0_upper);

    always_comb begin
        u1_valid_d = update0_valid;
        u1_upper_d = u0_upper;
        u1_hit_d   = update0_valid & (fwd_hit | cam_hit);
        u1_index_d = '0;
        if (update0_valid) begin
            u1_index_d = fwd_hit ? u1_index : cam_idx;
        end
    end

    // The update1 write wins over a concurrent global invalidate.
    always_comb begin
        entry_d = entry_q;
        valid_d = invalidate_all ? '0 : valid_q;
        if (u1_write) begin
            entry_d[u1_index] = u1_upper_q;
            valid_d[u1_index] = 1'b1;
        end
    end

    upct_plru #(
        .ENTRIES     (UPCT_ENTRIES),
        .LOG_ENTRIES (IW),
        .TOUCHES     (READ_PORTS + 1)
    ) u_plru (
        .CLK           (CLK),
        .nRST          (nRST),
        .clear_i       (invalidate_all),
        .touch_valid_i ({u1_valid_q,
                         read_valid_RESP & {READ_PORTS{~invalidate_all}}}),
        .touch_index_i ({u1_index, read_index_RESP}),
        .victim_o      (victim)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            entry_q    <= '0;
            valid_q    <= '0;
            u1_valid_q <= 1'b0;
            u1_hit_q   <= 1'b0;
            u1_upper_q <= '0;
            u1_index_q <= '0;
        end else begin
            entry_q    <= entry_d;
            valid_q    <= valid_d;
            u1_valid_q <= u1_valid_d;
            u1_hit_q   <= u1_hit_d;
            u1_upper_q <= u1_upper_d;
            u1_index_q <= u1_index_d;
        end
    end

endmodule

// File: tb/tb_upct_multi.sv
// Testbench for upct_multi: directed scenarios plus random traffic
// against a table/tree reference model.
module tb_upct_multi;
    import core_types_pkg::*;

    localparam int N  = UPCT_ENTRIES;
    localparam int L  = LOG_UPCT_ENTRIES;
    localparam int UW = UPPER_PC_WIDTH;

    logic                  CLK = 1'b0;
    logic                  nRST = 1'b0;
    logic [1:0]            read_valid_RESP = '0;
    logic [1:0][L-1:0]     read_index_RESP = '0;
    logic [1:0][UW-1:0]    read_upper_PC_RESP;
    logic                  update0_valid = 1'b0;
    logic [31:0]           update0_start_full_PC = '0;
    logic                  invalidate_all = 1'b0;
    logic                  update1_valid;
    logic [L-1:0]          update1_upct_index;
    logic                  update1_hit;

    int errors = 0;
    int checks = 0;

    upct_multi dut (
        .CLK                   (CLK),
        .nRST                  (nRST),
        .read_valid_RESP       (read_valid_RESP),
        .read_index_RESP       (read_index_RESP),
        .read_upper_PC_RESP    (read_upper_PC_RESP),
        .update0_valid         (update0_valid),
        .update0_start_full_PC (update0_start_full_PC),
        .invalidate_all        (invalidate_all),
        .update1_valid         (update1_valid),
        .update1_upct_index    (update1_upct_index),
        .update1_hit           (update1_hit)
    );

    always #5 CLK = ~CLK;

    // Reference model: table contents, valid flags, tree bits, and the
    // single update in flight between request and result.
    logic [UW-1:0] m_ent [N];
    bit            m_val [N];
    bit            m_plru [N-1];
    bit            p_v;
    bit            p_hit;
    logic [UW-1:0] p_up;
    upct_idx_t     p_idx;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_ent[i] = '0;
            m_val[i] = 1'b0;
        end
        for (int i = 0; i < N - 1; i++) m_plru[i] = 1'b0;
        p_v = 0; p_hit = 0; p_up = '0; p_idx = '0;
    endtask

    function automatic upct_idx_t m_victim();
        int n = 0;
        int v = 0;
        for (int l = 0; l < L; l++) begin
            v = v * 2 + int'(m_plru[n]);
            n = 2 * n + 1 + int'(m_plru[n]);
        end
        return upct_idx_t'(v);
    endfunction

    task automatic m_touch(input int idx);
        int n = 0;
        int b;
        for (int l = 0; l < L; l++) begin
            b = (idx >> (L - 1 - l)) & 1;
            m_plru[n] = (b == 0);
            n = 2 * n + 1 + b;
        end
    endtask

    task automatic do_reset();
        update0_valid   = 0;
        invalidate_all  = 0;
        read_valid_RESP = '0;
        nRST = 0;
        m_reset();
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1;
    endtask

    // One clock: drive inputs, check outputs against the model, advance
    // the model across the edge, then wait for the edge.
    task automatic step(input logic [1:0] rv, input int r0, input int r1,
                        input logic v, input logic [31:0] pc,
                        input logic inv);
        upct_idx_t     exp_idx;
        logic [UW-1:0] up;
        bit            hit;
        upct_idx_t     hidx;
        read_valid_RESP       = rv;
        read_index_RESP[0]    = upct_idx_t'(r0);
        read_index_RESP[1]    = upct_idx_t'(r1);
        update0_valid         = v;
        update0_start_full_PC = pc;
        invalidate_all        = inv;
        #1;
        chk("rd0", read_upper_PC_RESP[0], m_ent[r0]);
        chk("rd1", read_upper_PC_RESP[1], m_ent[r1]);
        chk("u1_valid", update1_valid, p_v);
        exp_idx = p_hit ? p_idx : m_victim();
        if (p_v) begin
            chk("u1_hit", update1_hit, p_hit);
            chk("u1_index", update1_upct_index, exp_idx);
        end
        if (inv) begin
            for (int i = 0; i < N; i++) m_val[i] = 0;
            for (int i = 0; i < N - 1; i++) m_plru[i] = 0;
        end
        if (p_v && !p_hit) begin
            m_ent[exp_idx] = p_up;
            m_val[exp_idx] = 1;
        end
        if (!inv) begin
            if (rv[0]) m_touch(r0);
            if (rv[1]) m_touch(r1);
        end
        if (p_v) m_touch(int'(exp_idx));
        up = pc[31 -: UW];
        hit = 0;
        hidx = '0;
        if (p_v && p_up == up) begin
            hit = 1;
            hidx = exp_idx;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_val[i] && m_ent[i] == up) begin
                    hit = 1;
                    hidx = upct_idx_t'(i);
                end
            end
        end
        p_v = v; p_up = up; p_hit = v && hit; p_idx = hidx;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input logic [1:0] rv, input int r0, input int r1);
        step(rv, r0, r1, 1'b0, 32'h0, 1'b0);
    endtask

    int order [9] = '{0, 4, 2, 6, 1, 5, 3, 7, 0};

    initial begin
        do_reset();
        chk("rst_u1_valid", update1_valid, 0);
        chk("rst_u1_index", update1_upct_index, 0);
        chk("rst_u1_hit", update1_hit, 0);
        chk("rst_rd0", read_upper_PC_RESP[0], 0);

        // First allocation and readback of 0x8000_1234.
        step(2'b00, 0, 0, 1'b1, 32'h8000_1234, 1'b0);
        chk("first_valid", update1_valid, 1);
        chk("first_hit", update1_hit, 0);
        chk("first_index", update1_upct_index, 0);
        idle(2'b01, 0, 0);
        chk("first_read", read_upper_PC_RESP[0], 32'h20_0004);

        // Back-to-back identical PCs: the second hits via forwarding.
        do_reset();
        step(2'b00, 0, 0, 1'b1, 32'hA000_0400, 1'b0);
        chk("b2b_first_hit", update1_hit, 0);
        chk("b2b_first_idx", update1_upct_index, 0);
        step(2'b00, 0, 0, 1'b1, 32'hA000_0400, 1'b0);
        chk("b2b_second_hit", update1_hit, 1);
        chk("b2b_second_idx", update1_upct_index, 0);
        step(2'b00, 0, 0, 1'b1, 32'hB000_0400, 1'b0);
        chk("b2b_no_realloc", update1_upct_index, 4);
        idle(2'b00, 0, 0);

        // Nine distinct PCs: tree-PLRU allocation order and wraparound.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(2'b00, 0, 0, 1'b1, (32'h100 + i) << 10, 1'b0);
            chk("fill_order", update1_upct_index, order[i]);
        end
        idle(2'b01, 0, 0);
        chk("evict_read", read_upper_PC_RESP[0], 32'h108);

        // Constant reads of entry 0 keep it away from the victim.
        do_reset();
        for (int i = 0; i < 8; i++)
            step(2'b00, 0, 0, 1'b1, (32'h200 + i) << 10, 1'b0);
        for (int i = 0; i < 4; i++) idle(2'b11, 0, 0);
        step(2'b11, 0, 0, 1'b1, 32'h300 << 10, 1'b0);
        chk("victim_not0", update1_upct_index != 0, 1);
        idle(2'b11, 0, 0);

        // Invalidate concurrent with a lookup of a present upper PC.
        do_reset();
        for (int i = 0; i < 6; i++)
            step(2'b00, 0, 0, 1'b1, (32'h400 + i) << 10, 1'b0);
        step(2'b00, 0, 0, 1'b1, 32'h12345 << 10, 1'b0);
        chk("inv_setup_idx", update1_upct_index, 3);
        idle(2'b00, 3, 3);
        chk("inv_setup_rd", read_upper_PC_RESP[0], 32'h12345);
        step(2'b00, 0, 0, 1'b1, 32'h12345 << 10, 1'b1);
        chk("inv_hit", update1_hit, 0);
        chk("inv_index", update1_upct_index, 0);
        step(2'b00, 0, 0, 1'b1, 32'h12345 << 10, 1'b0);
        chk("inv_again_hit", update1_hit, 1);
        chk("inv_again_idx", update1_upct_index, 0);
        idle(2'b00, 0, 0);

        // Reset while an update result is showing.
        step(2'b00, 0, 0, 1'b1, 32'h7777_0000, 1'b0);
        chk("pre_rst_valid", update1_valid, 1);
        nRST = 0;
        update0_valid = 0;
        #1;
        chk("mid_rst_valid", update1_valid, 0);
        chk("mid_rst_index", update1_upct_index, 0);
        chk("mid_rst_hit", update1_hit, 0);
        do_reset();
        for (int i = 0; i < N / 2; i++) idle(2'b00, 2 * i, 2 * i + 1);

        // Random traffic over a small pool of upper PCs.
        for (int i = 0; i < 400; i++) begin
            step(2'($urandom), int'($urandom_range(N - 1)),
                 int'($urandom_range(N - 1)),
                 $urandom_range(3) != 0,
                 ($urandom_range(11) + 32'h50) << 10 | 32'($urandom_range(1023)),
                 $urandom_range(24) == 0);
        end
        idle(2'b00, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
